// File: rtl/rib_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin bus arbiter: master count,
// FSM state encoding and hold-flag levels.
package rib_rr_arbiter_pkg;

    localparam int ARB_NUM_M = 4;
    localparam int ARB_IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    localparam logic HOLD_ENABLE  = 1'b1;
    localparam logic HOLD_DISABLE = 1'b0;

    // Master whose pending request stalls the core pipeline.
    localparam logic [ARB_IDX_W-1:0] HOLD_MASTER = 2'd1;

    // Reset pointer so that master 0 is the first candidate.
    localparam logic [ARB_IDX_W-1:0] ARB_PTR_RESET = 2'd3;

    function automatic logic [ARB_NUM_M-1:0] onehot(input logic [ARB_IDX_W-1:0] idx);
        return ARB_NUM_M'(1) << idx;
    endfunction

endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// Rotating first-one search: returns the first set request bit scanning
// ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
module rr_pick
    import rib_rr_arbiter_pkg::*;
(
    input  logic [ARB_NUM_M-1:0] req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] idx,
    output logic                 any
);

    logic [ARB_IDX_W-1:0] cand;

    // Scan farthest offset first so the nearest requester overwrites it.
    always_comb begin
        idx  = ptr;
        cand = ptr;
        for (int k = ARB_NUM_M; k >= 1; k--) begin
            cand = ptr + ARB_IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin bus arbiter with registered grant and a core stall flag.
// Optional owner preemption after TIMEOUT_CYCLES is enabled by RIB_ARB_TIMEOUT_EN.
module rib_rr_arbiter
    import rib_rr_arbiter_pkg::*;
#(
    parameter int NUM_M          = ARB_NUM_M,
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req_i,
    output logic [1:0]       grant_o,
    output logic             grant_valid_o,
    output logic             hold_flag_o,
    output logic             timeout_o
);

    arb_state_t     state;
    logic [1:0]     last_ptr;
    logic [NUM_M-1:0] cand_req;
    logic [1:0]     pick_idx;
    logic           pick_any;
    logic           owner_req;
    logic           preempt;

    assign owner_req = req_i[grant_o];

    // While owning, the current owner is excluded so a handover never regrants it.
    assign cand_req = (state == ST_OWN) ? (req_i & ~onehot(grant_o)) : req_i;

    rr_pick u_rr_pick (
        .req (cand_req),
        .ptr (last_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        hold_flag_o = HOLD_DISABLE;
        if (req_i[HOLD_MASTER] && !(grant_valid_o && (grant_o == HOLD_MASTER))) begin
            hold_flag_o = HOLD_ENABLE;
        end
        if ((state == ST_IDLE) && (|(req_i & ~onehot(HOLD_MASTER)))) begin
            hold_flag_o = HOLD_ENABLE;
        end
    end

`ifdef RIB_ARB_TIMEOUT_EN
    localparam logic [7:0] OWN_TERM = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] own_cnt;

    assign preempt = (own_cnt == OWN_TERM) && pick_any;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign preempt   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant_o       <= 2'd0;
            grant_valid_o <= 1'b0;
            last_ptr      <= ARB_PTR_RESET;
`ifdef RIB_ARB_TIMEOUT_EN
            timeout_o     <= 1'b0;
            own_cnt       <= 8'd0;
`endif
        end else begin
`ifdef RIB_ARB_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state         <= ST_OWN;
                        grant_o       <= pick_idx;
                        grant_valid_o <= 1'b1;
                        last_ptr      <= pick_idx;
`ifdef RIB_ARB_TIMEOUT_EN
                        own_cnt       <= 8'd0;
`endif
                    end
                end
                ST_OWN: begin
                    if (!owner_req || preempt) begin
                        if (pick_any) begin
                            grant_o  <= pick_idx;
                            last_ptr <= pick_idx;
`ifdef RIB_ARB_TIMEOUT_EN
                            timeout_o <= owner_req;
                            own_cnt   <= 8'd0;
`endif
                        end else begin
                            state         <= ST_IDLE;
                            grant_valid_o <= 1'b0;
`ifdef RIB_ARB_TIMEOUT_EN
                            own_cnt       <= 8'd0;
`endif
                        end
                    end
`ifdef RIB_ARB_TIMEOUT_EN
                    // Holds at the terminal count while the owner keeps the bus alone.
                    else if (own_cnt != OWN_TERM) begin
                        own_cnt <= own_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state         <= ST_IDLE;
                    grant_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Scoreboard bench for rib_rr_arbiter: directed request vectors push expected
// outputs; a monitor pops and compares one entry per clock.
module tb_rib_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_i = 4'b0000;
    logic [1:0] grant_o;
    logic       grant_valid_o;
    logic       hold_flag_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] g;
        logic       t;
        logic       h;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    rib_rr_arbiter #(
        .NUM_M          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .hold_flag_o   (hold_flag_o),
        .timeout_o     (timeout_o)
    );

    task automatic cmp_out(input string tag, input exp_t act, input exp_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got valid=%0b grant=%0d timeout=%0b hold=%0b, want valid=%0b grant=%0d timeout=%0b hold=%0b",
                     tag, act.v, act.g, act.t, act.h, want.v, want.g, want.t, want.h);
        end
    endtask

    task automatic cmp_bit(input string tag, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", tag, act, want);
        end
    endtask

    // Drive one request vector and queue the outputs expected after the next edge.
    task automatic step(input logic [3:0] r, input logic v, input logic [1:0] g,
                        input logic t, input logic h, input string tag);
        exp_t e;
        @(negedge clk);
        req_i = r;
        e.v = v; e.g = g; e.t = t; e.h = h;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t  want;
            string tag;
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            cmp_out(tag, {grant_valid_o, grant_o, timeout_o, hold_flag_o}, want);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        cmp_bit("rst_valid",   grant_valid_o, 1'b0);
        cmp_bit("rst_grant0",  grant_o[0],    1'b0);
        cmp_bit("rst_grant1",  grant_o[1],    1'b0);
        cmp_bit("rst_timeout", timeout_o,     1'b0);
        cmp_bit("rst_hold",    hold_flag_o,   1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin order from reset with all masters requesting.
        step(4'b1111, 1, 2'd0, 0, 1, "rr_first_0");
        step(4'b1110, 1, 2'd1, 0, 0, "rr_next_1");
        step(4'b1101, 1, 2'd2, 0, 0, "rr_next_2");
        step(4'b1011, 1, 2'd3, 0, 1, "rr_next_3");
        step(4'b0111, 1, 2'd0, 0, 1, "rr_wrap_0");
        step(4'b0111, 1, 2'd0, 0, 1, "rr_hold_0");
        step(4'b0000, 0, 2'd0, 0, 0, "rr_to_idle");

        // Handover without an idle bubble.
        step(4'b0100, 1, 2'd2, 0, 0, "nb_own_2");
        step(4'b1001, 1, 2'd3, 0, 0, "nb_hand_3");
        step(4'b0000, 0, 2'd3, 0, 0, "nb_idle");

        // Hold flag behaviour around master 1.
        step(4'b0010, 1, 2'd1, 0, 0, "hf_own_1");
        #1 cmp_bit("hf_idle_req1", hold_flag_o, 1'b1);
        step(4'b1010, 1, 2'd1, 0, 0, "hf_m1_keeps");
        #1 cmp_bit("hf_req3_m1own", hold_flag_o, 1'b0);
        step(4'b1000, 1, 2'd3, 0, 0, "hf_hand_3");
        step(4'b1000, 1, 2'd3, 0, 0, "rs_own_3");

        // Asynchronous reset in the middle of an ownership.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        cmp_bit("rs_async_valid", grant_valid_o, 1'b0);
        cmp_bit("rs_async_grant1", grant_o[1], 1'b0);
        #1 rst = 1'b0;
        begin
            exp_t e;
            e.v = 1'b1; e.g = 2'd3; e.t = 1'b0; e.h = 1'b0;
            exp_q.push_back(e);
            tag_q.push_back("rs_regrant_3");
        end
        step(4'b0000, 0, 2'd3, 0, 0, "rs_idle");

`ifdef RIB_ARB_TIMEOUT_EN
        // Preemption after 16 owned cycles, then no preemption when alone.
        step(4'b0101, 1, 2'd0, 0, 0, "to_grant_0");
        for (int i = 0; i < 15; i++) step(4'b0101, 1, 2'd0, 0, 0, "to_hold_0");
        step(4'b0101, 1, 2'd2, 1, 0, "to_preempt_2");
        step(4'b0101, 1, 2'd2, 0, 0, "to_pulse_end");
        step(4'b0000, 0, 2'd2, 0, 0, "to_idle");
        for (int i = 0; i < 40; i++) step(4'b0001, 1, 2'd0, 0, 0, "to_alone_0");
        step(4'b0000, 0, 2'd0, 0, 0, "to_idle2");
`else
        // No preemption without the timeout feature.
        for (int i = 0; i < 100; i++) step(4'b1111, 1, 2'd0, 0, 1, "nt_hold_0");
        step(4'b0000, 0, 2'd0, 0, 0, "nt_idle");
`endif

        @(negedge clk);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
